// File: rtl/aes_pkg.sv
// Shared AES types, inverse S-box and byte/state transforms for the decrypt datapath.
// All helpers are pure combinational functions over FIPS-197 column-major state.
package aes_pkg;
   typedef logic [127:0] state_t;
   typedef logic [7:0]   byte_t;

   localparam int AES128_NR = 10;

   localparam byte_t INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

   function automatic byte_t xtime(input byte_t a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gmul(input byte_t a, input byte_t b);
      byte_t p;
      byte_t x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Byte (r,c) lives at bits [127-8*(4c+r) -: 8]; row r moves right by r columns.
   function automatic state_t inv_shift_rows(input state_t s);
      state_t o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
      return o;
   endfunction

   function automatic state_t inv_sub_bytes(input state_t s);
      state_t o;
      o = '0;
      for (int k = 0; k < 16; k++)
         o[8*k +: 8] = INV_SBOX[s[8*k +: 8]];
      return o;
   endfunction
endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Block-in / block-out handshake plus round-key lookup bus of the iterative decrypt core.
interface aes_inv_cipher_iter_if #(parameter int RK_IDX_W = 4);
   import aes_pkg::*;
   logic                in_valid;
   logic                in_ready;
   state_t              ct_in;
   logic [RK_IDX_W-1:0] rk_idx;
   state_t              rk_in;
   logic                out_valid;
   logic                out_ready;
   state_t              pt_out;
   logic                busy;

   modport master (output in_valid, ct_in, rk_in, out_ready,
                   input  in_ready, rk_idx, out_valid, pt_out, busy);
   modport slave  (input  in_valid, ct_in, rk_in, out_ready,
                   output in_ready, rk_idx, out_valid, pt_out, busy);
endinterface

// File: rtl/aes_add_round_key.sv
// Shared AddRoundKey stage: pure XOR of state and round key, zero latency.
module aes_add_round_key import aes_pkg::*; (
   input  state_t data,
   input  state_t key,
   output state_t result
);
   assign result = data ^ key;
endmodule

// File: rtl/aes_inv_mix_columns.sv
// Combinational InvMixColumns over the full state, one instance per column.
// Each column multiplies by the circulant {0e,0b,0d,09} in GF(2^8).
module aes_inv_mix_column import aes_pkg::*; (
   input  logic [31:0] col,
   output logic [31:0] mixed
);
   byte_t a0, a1, a2, a3;
   assign {a0, a1, a2, a3} = col;
   assign mixed = {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
                   gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
                   gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
                   gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
endmodule

module aes_inv_mix_columns import aes_pkg::*; (
   input  state_t din,
   output state_t dout
);
   for (genvar c = 0; c < 4; c++) begin : g_col
      aes_inv_mix_column u_col (.col(din[127-32*c -: 32]), .mixed(dout[127-32*c -: 32]));
   end
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 decrypt, one round per clock; out_valid rises 10 cycles after acceptance.
// Backpressure: pt_out/out_valid held in DONE until out_ready; in_ready only while IDLE.
module aes_inv_cipher_iter import aes_pkg::*; #(
   parameter int NR       = 10,
   parameter int RK_IDX_W = 4
) (
   input logic                  clk,
   input logic                  rst_n,
   aes_inv_cipher_iter_if.slave bus
);
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ROUND = 2'd1;
   localparam logic [1:0] ST_FINAL = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   if (NR != AES128_NR) begin : g_bad_nr
      $error("aes_inv_cipher_iter supports only NR=10 (AES-128)");
   end

   logic [1:0] fsm;
   logic [3:0] round;
   logic [3:0] rk;
   logic       out_vld_q;
   state_t     st, pt_q, ark_in, ark_out, imc_out;

   // One AddRoundKey serves both the initial whitening and every later round.
   assign ark_in = (fsm == ST_IDLE) ? bus.ct_in : inv_sub_bytes(inv_shift_rows(st));

   aes_add_round_key   u_ark (.data(ark_in), .key(bus.rk_in), .result(ark_out));
   aes_inv_mix_columns u_imc (.din(ark_out), .dout(imc_out));

   always_comb begin
      rk = 4'(NR);
      case (fsm)
         ST_ROUND: rk = round;
         ST_FINAL: rk = 4'd0;
         default:  rk = 4'(NR);
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fsm       <= ST_IDLE;
         round     <= '0;
         st        <= '0;
         pt_q      <= '0;
         out_vld_q <= 1'b0;
      end else begin
         case (fsm)
            ST_IDLE: if (bus.in_valid) begin
               st    <= ark_out;
               round <= 4'(NR - 1);
               fsm   <= ST_ROUND;
            end
            ST_ROUND: begin
               st <= imc_out;
               if (round == 4'd1) begin
                  round <= 4'd0;
                  fsm   <= ST_FINAL;
               end else begin
                  round <= round - 4'd1;
               end
            end
            ST_FINAL: begin
               pt_q      <= ark_out;
               out_vld_q <= 1'b1;
               fsm       <= ST_DONE;
            end
            default: if (bus.out_ready) begin
               out_vld_q <= 1'b0;
               fsm       <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (fsm == ST_IDLE);
   assign bus.busy      = (fsm != ST_IDLE);
   assign bus.out_valid = out_vld_q;
   assign bus.pt_out    = pt_q;
   assign bus.rk_idx    = RK_IDX_W'(rk);
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Scoreboarded bench for aes_inv_cipher_iter: FIPS-197 vectors, backpressure, back-to-back, mid-run reset.
module tb_aes_inv_cipher_iter;
   localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   aes_inv_cipher_iter_if #(.RK_IDX_W(4)) bus ();
   aes_inv_cipher_iter #(.NR(10), .RK_IDX_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [7:0]   sbox [256];
   logic [127:0] rk_tab [11];
   logic [127:0] sb [$];
   int           acc_q [$];
   logic [3:0]   rk_q [$];
   logic [127:0] exp_drv;
   int           n_cmp = 0, n_err = 0, acc_cnt = 0, cyc = 0;
   logic         rec_arm = 1'b0, rec_on = 1'b0;

   assign bus.rk_in = (bus.rk_idx <= 4'd10) ? rk_tab[bus.rk_idx] : '0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Forward S-box from first principles: GF inverse followed by the affine map.
   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = '0;
         for (int y = 1; y < 256; y++)
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   task automatic load_key(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
            rc = gm(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      logic [127:0] e;
      if (rst_n && bus.in_valid && bus.in_ready) begin
         sb.push_back(exp_drv);
         acc_q.push_back(cyc);
         acc_cnt++;
         if (rec_arm) rec_on = 1'b1;
      end
      if (rec_on) rk_q.push_back(bus.rk_idx);
      if (rst_n && bus.out_valid && bus.out_ready) begin
         check("sb_nonempty", 128'(sb.size() != 0), 128'(1));
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pt", bus.pt_out, e);
         end
      end
   end

   task automatic send(input logic [127:0] ct, input logic [127:0] pt);
      int n;
      @(posedge clk); #1;
      bus.ct_in = ct;
      exp_drv = pt;
      bus.in_valid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.in_ready && n < 100);
      check("accept_rdy", 128'(bus.in_ready), 128'(1));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while ((sb.size() != 0 || bus.busy) && n < 100);
      check("drain_sb", 128'(sb.size()), 128'(0));
      check("drain_busy", 128'(bus.busy), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n, a0, bad;
      logic [127:0] snap;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.ct_in = '0;
      bus.out_ready = 1'b1;
      exp_drv = '0;
      build_sbox();
      load_key(K_C1);
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 128'(bus.out_valid), 128'(0));
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_pt_out", bus.pt_out, 128'(0));
      check("rst_in_ready", 128'(bus.in_ready), 128'(1));
      check("rst_rk_idx", 128'(bus.rk_idx), 128'(10));
      rst_n = 1'b1;

      // FIPS-197 C.1 with latency measurement
      send(CT_C1, PT_C1);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.out_valid && n < 50);
      check("c1_latency", 128'(n - 1), 128'(10));
      wait_idle();

      // FIPS-197 Appendix B
      load_key(K_B);
      send(CT_B, PT_B);
      wait_idle();

      // Backpressure: output held, second block refused
      bus.out_ready = 1'b0;
      send(CT_B, PT_B);
      n = 0;
      while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
      check("bp_out_valid", 128'(bus.out_valid), 128'(1));
      bus.ct_in = CT_Z;
      exp_drv = '1;
      bus.in_valid = 1'b1;
      a0 = acc_cnt;
      snap = bus.pt_out;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.pt_out !== snap || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
      end
      check("bp_hold_bad", 128'(bad), 128'(0));
      check("bp_pt", bus.pt_out, PT_B);
      check("bp_no_accept", 128'(acc_cnt), 128'(a0));
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      wait_idle();

      // Back-to-back: in_valid held over three blocks
      load_key(K_C1);
      acc_q.delete();
      rk_q.delete();
      rec_arm = 1'b1;
      @(posedge clk); #1;
      bus.ct_in = CT_C1;
      exp_drv = PT_C1;
      bus.in_valid = 1'b1;
      a0 = acc_cnt;
      n = 0;
      while (acc_cnt < a0 + 3 && n < 100) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("b2b_accepts", 128'(acc_cnt - a0), 128'(3));
      n = 0;
      while (rk_q.size() < 36 && n < 100) begin @(negedge clk); n++; end
      rec_arm = 1'b0;
      rec_on = 1'b0;
      bad = 0;
      for (int i = 0; i < 36; i++) begin
         int p;
         logic [3:0] e;
         p = i % 12;
         e = (p == 0 || p == 11) ? 4'd10 : (p == 10) ? 4'd0 : 4'(10 - p);
         if (i >= rk_q.size() || rk_q[i] !== e) bad++;
      end
      check("b2b_rk_seq", 128'(bad), 128'(0));
      if (acc_q.size() >= 3) begin
         check("b2b_gap1", 128'(acc_q[1] - acc_q[0]), 128'(12));
         check("b2b_gap2", 128'(acc_q[2] - acc_q[1]), 128'(12));
      end
      wait_idle();

      // Reset at round 5 abandons the block; reset wins over in_valid
      send(CT_C1, PT_C1);
      n = 0;
      while (bus.rk_idx != 4'd5 && n < 50) begin @(negedge clk); n++; end
      check("rst_mid_round", 128'(bus.rk_idx), 128'(5));
      rst_n = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_out_valid", 128'(bus.out_valid), 128'(0));
      check("rst_mid_busy", 128'(bus.busy), 128'(0));
      check("rst_mid_in_ready", 128'(bus.in_ready), 128'(1));
      sb.delete();
      rst_n = 1'b1;
      bus.in_valid = 1'b0;
      send(CT_C1, PT_C1);
      wait_idle();

      // All-zero key
      load_key(128'h0);
      send(CT_Z, 128'h0);
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
